control_reg_writer: RTL and testbench
=====================================

# control_reg_writer

Register-driven control output: software or a bus master writes an 8-bit value through a valid/ready handshake, and the block drives those bits onto hardware nets. It is the write-direction counterpart of the status register, which carries nets to software. Each bit is configured as level (held until rewritten) or pulse (self-clearing after a fixed number of clocks). It sits between the bus-interface logic and UDB/fabric nets.

## Interface
- NumOutputs, 8, active bits (1..8); bits at or above NumOutputs are tied to 0 in all outputs and readback.
- BitModes, 8'h00, per-bit mode: 0 = level, 1 = pulse.
- ResetValue, 8'h00, reset value of the level bits; ignored for pulse bits.
- PulseWidth, 1, pulse-mode high time in clocks (1..15).

Ports:
- clock  in  1  single clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- wr_valid  in  1  write request.
- wr_ready  out  1  block can accept a write.
- wr_data  in  8  write data.
- wr_mask  in  8  per-bit write enable.
- control_0 .. control_7  out  1 each  individual control nets.
- control_bus  out  8  same values as a bus.
- rd_data  out  8  readback, equal to control_bus.
- pulse_done  out  1  one-clock strobe when a pulse ends.

## Operation
- Effective mask: `em = wr_mask & ((1<<NumOutputs)-1)`.
- Level mask: `LM = ~BitModes & em`. Pulse mask: `PM = BitModes & em`.
- A write is accepted when wr_valid && wr_ready on a clock edge.
- Level bits: `ctrl <= (ctrl & ~LM) | (wr_data & LM)`.
- Pulse bits:
  - A bit written 1 with its mask bit set goes high.
  - Writing 0 to a pulse bit has no effect.
  - An accepted write that sets no pulse bit stays in IDLE.
- FSM states:
  - IDLE: wr_ready=1. An accepted write with any pulse bit set loads count=1 and goes to PULSE.
  - PULSE: wr_ready=0. If count==PulseWidth, clear all pulse bits, assert pulse_done, go to IDLE. Otherwise count++.
- Level and pulse bits in the same write are applied on the same edge.
- wr_ready is a function of state only; it is never combinationally dependent on wr_valid.
- Reset values:
  - Level bits = ResetValue & ~BitModes, masked to NumOutputs.
  - Pulse bits = 0.
  - State IDLE, count 0, pulse_done 0.
  - wr_ready = 1 from the first clock after reset deasserts. While reset is asserted, wr_ready = 0.
- Reset mid-pulse: pulse bits drop on that edge; no pulse_done is generated.

## Timing
- Write accepted at edge N: control outputs are updated after edge N. Latency is 1 clock; outputs are registered and glitch-free.
- Pulse bits are high for exactly PulseWidth clocks, from edge N to edge N+PulseWidth.
- pulse_done is high in the cycle after edge N+PulseWidth, concurrent with the pulse bit(s) returning to 0 and wr_ready returning to 1.
- A write presented during PULSE is held off (wr_ready=0) and accepted on the first IDLE edge. No write is lost or merged.
- Back-to-back level-only writes are accepted every clock.
- count width is 4; PulseWidth outside 1..15 is a parameter error, enforced with an elaboration-time check.

## Structure
- Package control_reg_pkg:
  - FSM state enum (IDLE, PULSE).
  - COUNT_W = 4, MAX_PULSE_WIDTH = 15.
  - Function computing the active-bit mask from NumOutputs.
- Sub-module control_pulse_timer:
  - Contains the FSM and counter.
  - Inputs: start, PulseWidth. Outputs: busy, done.
  - The top level holds the register, the masking and the output fan-out.

## Test plan
- Reset with ResetValue=8'hA5, BitModes=8'h0F → control_bus=8'hA0, wr_ready=1 after reset, pulse_done=0.
- All level, NumOutputs=8: write data 8'h3C, mask 8'hFF; then data 8'hFF, mask 8'h0F → bus 8'h3C then 8'h3F, one clock after each accept.
- BitModes=8'h01, PulseWidth=3: write data 8'h81, mask 8'hFF →
  - bit7=1 persistently.
  - bit0 high exactly 3 clocks.
  - pulse_done one clock at fall.
  - wr_ready low for 3 clocks.
- Write held during PULSE: wr_valid stays high with data 8'h02 → accepted on the first IDLE edge; bus shows bit1 the next clock.
- NumOutputs=4: write data 8'hFF, mask 8'hFF → bus 8'h0F; control_4..7 stay 0.
- Reset asserted in the 2nd of 3 pulse clocks → bit0 drops on that edge, no pulse_done, state IDLE, level bits return to ResetValue.

Source files
------------

// File: rtl/control_reg_writer_pkg.sv
// control_reg_pkg: shared types and constants for the control register writer.
//   pulse_state_e   : pulse timer FSM state (IDLE, PULSE)
//   COUNT_W         : pulse counter width
//   MAX_PULSE_WIDTH : largest legal pulse high time in clocks
//   DATA_W          : width of the write data / control bus
//   active_mask()   : mask with the low num_outputs bits set
package control_reg_pkg;

  localparam int COUNT_W         = 4;
  localparam int MAX_PULSE_WIDTH = 15;
  localparam int DATA_W          = 8;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    PULSE = 1'b1
  } pulse_state_e;

  // Bits at or above num_outputs are unused and must read as zero everywhere.
  function automatic logic [DATA_W-1:0] active_mask(input int num_outputs);
    logic [DATA_W-1:0] m;
    m = {DATA_W{1'b0}};
    for (int i = 0; i < DATA_W; i++) begin
      if (i < num_outputs) begin
        m[i] = 1'b1;
      end else begin
        m[i] = 1'b0;
      end
    end
    return m;
  endfunction

endpackage

// File: rtl/control_reg_writer_if.sv
// control_reg_writer_if: valid/ready write channel into the control register.
//   wr_valid : write request (master -> slave)
//   wr_ready : slave can accept a write (slave -> master)
//   wr_data  : write data
//   wr_mask  : per-bit write enable
interface control_reg_writer_if;
  import control_reg_pkg::*;

  logic              wr_valid;
  logic              wr_ready;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] wr_mask;

  modport master (output wr_valid, output wr_data, output wr_mask, input wr_ready);
  modport slave  (input wr_valid, input wr_data, input wr_mask, output wr_ready);

endinterface

// File: rtl/control_reg_writer_pulse_timer.sv
// control_pulse_timer: times the high phase of pulse-mode control bits.
//   clock  : rising-edge clock
//   reset  : synchronous active-high reset
//   start  : accepted write that sets at least one pulse bit (sampled in IDLE)
//   busy   : a pulse is in progress (writes must be held off)
//   expire : last pulse clock; pulse bits clear on this edge
//   done   : registered one-clock strobe in the cycle after the pulse ends
module control_pulse_timer
  import control_reg_pkg::*;
#(
  parameter int PulseWidth = 1
) (
  input  logic clock,
  input  logic reset,
  input  logic start,
  output logic busy,
  output logic expire,
  output logic done
);

  localparam logic [COUNT_W-1:0] PW_CNT  = COUNT_W'(PulseWidth);
  localparam logic [COUNT_W-1:0] CNT_ONE = COUNT_W'(1);
  localparam logic [COUNT_W-1:0] CNT_ZERO = COUNT_W'(0);

  generate
    if (PulseWidth < 1 || PulseWidth > MAX_PULSE_WIDTH) begin : g_bad_pulse_width
      $error("control_pulse_timer: PulseWidth must be in 1..15");
    end
  endgenerate

  pulse_state_e       state_r;
  pulse_state_e       state_next_s;
  logic [COUNT_W-1:0] count_r;
  logic [COUNT_W-1:0] count_next_s;
  logic               done_r;
  logic               busy_s;
  logic               expire_s;

  // State, counter and done-strobe registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= IDLE;
      count_r <= CNT_ZERO;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_next_s;
      count_r <= count_next_s;
      done_r  <= expire_s;
    end
  end

  // Next-state and next-count logic; count 1 marks the first high clock.
  always_comb begin
    state_next_s = state_r;
    count_next_s = count_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_next_s = PULSE;
          count_next_s = CNT_ONE;
        end else begin
          state_next_s = IDLE;
          count_next_s = count_r;
        end
      end
      PULSE: begin
        if (count_r == PW_CNT) begin
          state_next_s = IDLE;
          count_next_s = CNT_ZERO;
        end else begin
          state_next_s = PULSE;
          count_next_s = count_r + CNT_ONE;
        end
      end
      default: begin
        state_next_s = IDLE;
        count_next_s = CNT_ZERO;
      end
    endcase
  end

  // State decode for busy and the final-clock indication.
  always_comb begin
    busy_s   = 1'b0;
    expire_s = 1'b0;
    case (state_r)
      IDLE: begin
        busy_s   = 1'b0;
        expire_s = 1'b0;
      end
      PULSE: begin
        busy_s   = 1'b1;
        expire_s = (count_r == PW_CNT);
      end
      default: begin
        busy_s   = 1'b0;
        expire_s = 1'b0;
      end
    endcase
  end

  assign busy   = busy_s;
  assign expire = expire_s;
  assign done   = done_r;

endmodule

// File: rtl/control_reg_writer.sv
// control_reg_writer: software-written control register driving fabric nets.
//   clock, reset          : rising-edge clock, synchronous active-high reset
//   bus (slave)           : wr_valid/wr_ready/wr_data/wr_mask write channel
//   control_0..control_7  : individual control nets
//   control_bus, rd_data  : the same register as a bus / readback
//   pulse_done            : one-clock strobe after pulse bits drop
// Each bit is level (held) or pulse (self-clearing after PulseWidth clocks).
module control_reg_writer
  import control_reg_pkg::*;
#(
  parameter int                NumOutputs = 8,
  parameter logic [DATA_W-1:0] BitModes   = 8'h00,
  parameter logic [DATA_W-1:0] ResetValue = 8'h00,
  parameter int                PulseWidth = 1
) (
  input  logic                clock,
  input  logic                reset,
  control_reg_writer_if.slave bus,
  output logic                control_0,
  output logic                control_1,
  output logic                control_2,
  output logic                control_3,
  output logic                control_4,
  output logic                control_5,
  output logic                control_6,
  output logic                control_7,
  output logic [DATA_W-1:0]   control_bus,
  output logic [DATA_W-1:0]   rd_data,
  output logic                pulse_done
);

  localparam logic [DATA_W-1:0] ACTIVE_MASK = active_mask(NumOutputs);
  localparam logic [DATA_W-1:0] PULSE_BITS  = BitModes & ACTIVE_MASK;
  localparam logic [DATA_W-1:0] CTRL_RESET  = ResetValue & ~BitModes & ACTIVE_MASK;

  generate
    if (NumOutputs < 1 || NumOutputs > DATA_W) begin : g_bad_num_outputs
      $error("control_reg_writer: NumOutputs must be in 1..8");
    end
  endgenerate

  logic [DATA_W-1:0] ctrl_r;
  logic [DATA_W-1:0] ctrl_next_s;
  logic              ready_en_r;
  logic [DATA_W-1:0] em_s;
  logic [DATA_W-1:0] lm_s;
  logic [DATA_W-1:0] pm_s;
  logic              accept_s;
  logic              start_s;
  logic              busy_s;
  logic              expire_s;

  // wr_ready depends on registered state only, never on wr_valid.
  assign bus.wr_ready = ready_en_r & ~busy_s;

  assign em_s     = bus.wr_mask & ACTIVE_MASK;
  assign lm_s     = ~BitModes & em_s;
  assign pm_s     = BitModes & em_s;
  assign accept_s = bus.wr_valid & bus.wr_ready;
  assign start_s  = accept_s & (|(bus.wr_data & pm_s));

  control_pulse_timer #(
    .PulseWidth (PulseWidth)
  ) u_pulse_timer (
    .clock  (clock),
    .reset  (reset),
    .start  (start_s),
    .busy   (busy_s),
    .expire (expire_s),
    .done   (pulse_done)
  );

  // Next register value; accept and expire are exclusive (IDLE vs PULSE).
  always_comb begin
    ctrl_next_s = ctrl_r;
    if (accept_s) begin
      // Pulse bits are all zero in IDLE, so OR-ing in the new pulses is safe.
      ctrl_next_s = (ctrl_r & ~lm_s) | (bus.wr_data & lm_s) | (bus.wr_data & pm_s);
    end else if (expire_s) begin
      ctrl_next_s = ctrl_r & ~PULSE_BITS;
    end else begin
      ctrl_next_s = ctrl_r;
    end
  end

  // Control register and the post-reset ready enable.
  always_ff @(posedge clock) begin
    if (reset) begin
      ctrl_r     <= CTRL_RESET;
      ready_en_r <= 1'b0;
    end else begin
      ctrl_r     <= ctrl_next_s;
      ready_en_r <= 1'b1;
    end
  end

  assign control_bus = ctrl_r;
  assign rd_data     = ctrl_r;
  assign control_0   = ctrl_r[0];
  assign control_1   = ctrl_r[1];
  assign control_2   = ctrl_r[2];
  assign control_3   = ctrl_r[3];
  assign control_4   = ctrl_r[4];
  assign control_5   = ctrl_r[5];
  assign control_6   = ctrl_r[6];
  assign control_7   = ctrl_r[7];

endmodule

// File: tb/tb_control_reg_writer.sv
// tb_control_reg_writer: four differently configured instances share one
// stimulus channel (tb_sel picks which one sees wr_valid).
//   0: N=8, modes 0F, reset A5, width 1
//   1: N=8, all level, reset 00, width 1
//   2: N=8, modes 01, reset 44, width 3
//   3: N=4, all level, reset 00, width 1
module tb_control_reg_writer;

  logic       clock;
  logic       reset;
  logic       tb_valid;
  int         tb_sel;
  logic [7:0] tb_data;
  logic [7:0] tb_mask;

  logic [3:0][7:0] bus_o;
  logic [3:0][7:0] rd_o;
  logic [3:0][7:0] ctl;
  logic [3:0]      rdy_o;
  logic [3:0]      done_o;

  int n_pass;
  int n_total;

  typedef struct {
    int         sel;
    logic [7:0] data;
    logic [7:0] mask;
    logic [7:0] exp;
  } vec_t;

  typedef struct {
    int         sel;
    logic [7:0] bus;
  } exp_t;

  vec_t vecs[8];
  exp_t exp_q[$];

  control_reg_writer_if if_a ();
  control_reg_writer_if if_b ();
  control_reg_writer_if if_c ();
  control_reg_writer_if if_d ();

  assign if_a.wr_valid = tb_valid && (tb_sel == 0);
  assign if_b.wr_valid = tb_valid && (tb_sel == 1);
  assign if_c.wr_valid = tb_valid && (tb_sel == 2);
  assign if_d.wr_valid = tb_valid && (tb_sel == 3);
  assign if_a.wr_data = tb_data;
  assign if_b.wr_data = tb_data;
  assign if_c.wr_data = tb_data;
  assign if_d.wr_data = tb_data;
  assign if_a.wr_mask = tb_mask;
  assign if_b.wr_mask = tb_mask;
  assign if_c.wr_mask = tb_mask;
  assign if_d.wr_mask = tb_mask;
  assign rdy_o = {if_d.wr_ready, if_c.wr_ready, if_b.wr_ready, if_a.wr_ready};

  control_reg_writer #(.NumOutputs(8), .BitModes(8'h0F), .ResetValue(8'hA5), .PulseWidth(1)) u_a (
    .clock(clock), .reset(reset), .bus(if_a),
    .control_0(ctl[0][0]), .control_1(ctl[0][1]), .control_2(ctl[0][2]), .control_3(ctl[0][3]),
    .control_4(ctl[0][4]), .control_5(ctl[0][5]), .control_6(ctl[0][6]), .control_7(ctl[0][7]),
    .control_bus(bus_o[0]), .rd_data(rd_o[0]), .pulse_done(done_o[0]));

  control_reg_writer #(.NumOutputs(8), .BitModes(8'h00), .ResetValue(8'h00), .PulseWidth(1)) u_b (
    .clock(clock), .reset(reset), .bus(if_b),
    .control_0(ctl[1][0]), .control_1(ctl[1][1]), .control_2(ctl[1][2]), .control_3(ctl[1][3]),
    .control_4(ctl[1][4]), .control_5(ctl[1][5]), .control_6(ctl[1][6]), .control_7(ctl[1][7]),
    .control_bus(bus_o[1]), .rd_data(rd_o[1]), .pulse_done(done_o[1]));

  control_reg_writer #(.NumOutputs(8), .BitModes(8'h01), .ResetValue(8'h44), .PulseWidth(3)) u_c (
    .clock(clock), .reset(reset), .bus(if_c),
    .control_0(ctl[2][0]), .control_1(ctl[2][1]), .control_2(ctl[2][2]), .control_3(ctl[2][3]),
    .control_4(ctl[2][4]), .control_5(ctl[2][5]), .control_6(ctl[2][6]), .control_7(ctl[2][7]),
    .control_bus(bus_o[2]), .rd_data(rd_o[2]), .pulse_done(done_o[2]));

  control_reg_writer #(.NumOutputs(4), .BitModes(8'h00), .ResetValue(8'h00), .PulseWidth(1)) u_d (
    .clock(clock), .reset(reset), .bus(if_d),
    .control_0(ctl[3][0]), .control_1(ctl[3][1]), .control_2(ctl[3][2]), .control_3(ctl[3][3]),
    .control_4(ctl[3][4]), .control_5(ctl[3][5]), .control_6(ctl[3][6]), .control_7(ctl[3][7]),
    .control_bus(bus_o[3]), .rd_data(rd_o[3]), .pulse_done(done_o[3]));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Sample one instance's bus/readback/ready/done at a negedge.
  task automatic sample(input string name, input int s, input logic [7:0] eb,
                        input logic er, input logic ed);
    check({name, "_bus"}, bus_o[s], eb);
    check({name, "_rd"}, rd_o[s], eb);
    check({name, "_rdy"}, {7'd0, rdy_o[s]}, {7'd0, er});
    check({name, "_done"}, {7'd0, done_o[s]}, {7'd0, ed});
  endtask

  // Compare the oldest expected bus value with what the DUT now shows.
  task automatic pop_check(input string name);
    exp_t e;
    if (exp_q.size() == 0) begin
      n_total++;
      $display("FAIL %s: scoreboard empty, got nothing expected an entry", name);
    end else begin
      e = exp_q.pop_front();
      check({name, "_bus"}, bus_o[e.sel], e.bus);
      check({name, "_rd"}, rd_o[e.sel], e.bus);
      check({name, "_nets"}, ctl[e.sel], e.bus);
    end
  endtask

  // Issue one write (called at a negedge), then score it one clock later.
  task automatic do_write(input string name, input int s, input logic [7:0] d,
                          input logic [7:0] m, input logic [7:0] exp);
    int waited;
    waited = 0;
    tb_sel = s; tb_data = d; tb_mask = m; tb_valid = 1'b1;
    while (!rdy_o[s] && waited < 40) begin
      @(negedge clock);
      waited++;
    end
    if (!rdy_o[s]) begin
      n_total++;
      $display("FAIL %s_ready_wait: got ready 0 expected ready 1 within 40 clocks", name);
    end
    @(posedge clock);
    exp_q.push_back('{s, exp});
    @(negedge clock);
    tb_valid = 1'b0;
    pop_check(name);
  endtask

  initial begin
    logic [7:0] pb[6];
    logic       pr[6];
    logic       pd[6];
    n_pass = 0; n_total = 0;
    tb_valid = 1'b0; tb_sel = 0; tb_data = 8'h00; tb_mask = 8'h00;
    reset = 1'b1;

    vecs[0] = '{1, 8'h3C, 8'hFF, 8'h3C};
    vecs[1] = '{1, 8'hFF, 8'h0F, 8'h3F};
    vecs[2] = '{1, 8'h00, 8'hF0, 8'h0F};
    vecs[3] = '{1, 8'h5A, 8'h00, 8'h0F};
    vecs[4] = '{3, 8'hFF, 8'hFF, 8'h0F};
    vecs[5] = '{3, 8'h00, 8'h0C, 8'h03};
    vecs[6] = '{0, 8'hFF, 8'hF0, 8'hF0};
    vecs[7] = '{2, 8'h80, 8'hFF, 8'h80};

    // Reset state, during and after reset.
    @(negedge clock);
    @(negedge clock);
    check("rst_ready_low", {4'd0, rdy_o}, 8'h00);
    check("rst_bus_a", bus_o[0], 8'hA0);
    reset = 1'b0;
    @(negedge clock);
    check("rst_ready_high", {4'd0, rdy_o}, 8'h0F);
    check("rst_done", {4'd0, done_o}, 8'h00);
    check("rst_bus_a_after", bus_o[0], 8'hA0);
    check("rst_rd_a", rd_o[0], 8'hA0);
    check("rst_bus_c", bus_o[2], 8'h44);
    check("rst_bus_d", bus_o[3], 8'h00);

    // Table-driven single writes.
    for (int i = 0; i < 8; i++) begin
      do_write($sformatf("vec%0d", i), vecs[i].sel, vecs[i].data, vecs[i].mask, vecs[i].exp);
    end

    // Back-to-back level writes, one accepted per clock.
    tb_sel = 1; tb_mask = 8'hFF; tb_valid = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tb_data = 8'(i * 17);
      @(negedge clock);
      sample($sformatf("b2b%0d", i), 1, 8'(i * 17), 1'b1, 1'b0);
    end
    tb_valid = 1'b0;

    // PulseWidth=1 on instance 0: level upper nibble cleared, bits 0/2 pulse.
    tb_sel = 0; tb_data = 8'h05; tb_mask = 8'hFF; tb_valid = 1'b1;
    @(negedge clock);
    tb_valid = 1'b0;
    sample("pw1_e0", 0, 8'h05, 1'b0, 1'b0);
    @(negedge clock);
    sample("pw1_e1", 0, 8'h00, 1'b1, 1'b1);
    @(negedge clock);
    sample("pw1_e2", 0, 8'h00, 1'b1, 1'b0);

    // PulseWidth=3 with a second write held off during the pulse.
    pb = '{8'h81, 8'h81, 8'h81, 8'h80, 8'h82, 8'h82};
    pr = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    pd = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    tb_sel = 2; tb_data = 8'h81; tb_mask = 8'hFF; tb_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      if (i == 0) begin
        tb_data = 8'h02; tb_mask = 8'h02;
      end
      if (i == 4) begin
        tb_valid = 1'b0;
      end
      sample($sformatf("pw3_e%0d", i), 2, pb[i], pr[i], pd[i]);
    end

    // Reset asserted in the second of three pulse clocks.
    tb_sel = 2; tb_data = 8'h81; tb_mask = 8'hFF; tb_valid = 1'b1;
    @(negedge clock);
    tb_valid = 1'b0;
    sample("mid_e0", 2, 8'h81, 1'b0, 1'b0);
    @(negedge clock);
    sample("mid_e1", 2, 8'h81, 1'b0, 1'b0);
    reset = 1'b1;
    @(negedge clock);
    sample("mid_e2", 2, 8'h44, 1'b0, 1'b0);
    reset = 1'b0;
    @(negedge clock);
    sample("mid_e3", 2, 8'h44, 1'b1, 1'b0);
    @(negedge clock);
    sample("mid_e4", 2, 8'h44, 1'b1, 1'b0);
    check("mid_bus_a", bus_o[0], 8'hA0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
